// File: rtl/uart_tx_serializer.sv
// Serial transmitter: accepts a parallel word over valid/ready and emits a framed
// bit stream (start, data LSB first, optional even parity, stop) on a single line.
module uart_tx_serializer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [BW-1:0]    bit_idx;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic             parity_bit;
  logic             bit_end;

  assign shreg_nxt = shreg >> 1;
  assign bit_end   = (timer == T_LAST);

  // NOTE: all state and outputs use non-blocking assignments; outputs are loaded
  // with the value belonging to the state being entered, so they are registered
  // and change in the cycle right after the transition edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      load_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          timer   <= '0;
          bit_idx <= '0;
          if (load_valid) begin
            shreg      <= data_in;
            parity_bit <= ^data_in;
            state      <= S_START;
            tx         <= 1'b0;
            busy       <= 1'b1;
            load_ready <= 1'b0;
          end
        end

        S_START: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
            tx      <= shreg[0];
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            timer <= '0;
            shreg <= shreg_nxt;
            if (bit_idx == B_LAST) begin
              if (PARITY_EN != 0) begin
                state <= S_PARITY;
                tx    <= parity_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
              tx      <= shreg_nxt[0];
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            timer <= '0;
            state <= S_STOP;
            tx    <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_STOP: begin
          if (bit_end) begin
            timer      <= '0;
            state      <= S_IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            load_ready <= 1'b1;
            done       <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: begin
          state      <= S_IDLE;
          timer      <= '0;
          tx         <= 1'b1;
          busy       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: three instances cover the default frame,
// the parity frame and the one-cycle-per-bit frame.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic [2:0] lv;
  logic [2:0] rdy, txs, bsy, dn;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_base (
    .clk(clk), .reset(reset), .data_in(din), .load_valid(lv[0]),
    .load_ready(rdy[0]), .tx(txs[0]), .busy(bsy[0]), .done(dn[0])
  );

  uart_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_par (
    .clk(clk), .reset(reset), .data_in(din), .load_valid(lv[1]),
    .load_ready(rdy[1]), .tx(txs[1]), .busy(bsy[1]), .done(dn[1])
  );

  uart_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_fast (
    .clk(clk), .reset(reset), .data_in(din), .load_valid(lv[2]),
    .load_ready(rdy[2]), .tx(txs[2]), .busy(bsy[2]), .done(dn[2])
  );

  // Observed status packed as {tx, busy, done, load_ready}.
  function automatic logic [3:0] mon(input int s);
    return {txs[s], bsy[s], dn[s], rdy[s]};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed {tx,busy,done,ready}=%b expected %b", tag, obs, exp);
  endtask

  // Caller is at the negedge of cycle 1 after the accepting edge; returns at the
  // negedge of the done cycle.
  task automatic check_frame(input int s, input logic [7:0] w, input int cpb,
                             input int pen, input string tag);
    logic [10:0] fr;
    int          nb;
    nb    = 10 + pen;
    fr    = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[i+1] = w[i];
    if (pen != 0) fr[9] = ^w;
    for (int c = 0; c < nb * cpb; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("%s cycle%0d", tag, c + 1), mon(s), {fr[c / cpb], 1'b1, 1'b0, 1'b0});
    end
    @(negedge clk);
    check($sformatf("%s done", tag), mon(s), 4'b1011);
  endtask

  initial begin
    reset = 1'b1;
    lv    = '0;
    din   = '0;

    // T1: plain reset, then reset held across a valid request
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) check($sformatf("t1 reset inst%0d", s), mon(s), 4'b1001);
    lv  = 3'b111;
    din = 8'h5A;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) check($sformatf("t1 reset+valid inst%0d", s), mon(s), 4'b1001);
    lv    = '0;
    reset = 1'b0;
    @(negedge clk);
    check("t1 no accept after reset", mon(0), 4'b1001);

    // T2: 0xA5, 4 clocks per bit
    din   = 8'hA5;
    lv[0] = 1'b1;
    @(negedge clk);
    lv[0] = 1'b0;
    din   = 8'h00;
    check_frame(0, 8'hA5, 4, 0, "t2 A5");
    @(negedge clk);
    check("t2 idle after done", mon(0), 4'b1001);

    // T3: back-to-back with load_valid held through the first frame
    din   = 8'h00;
    lv[0] = 1'b1;
    @(negedge clk);
    din = 8'hFF;
    check_frame(0, 8'h00, 4, 0, "t3 first");
    @(negedge clk);
    lv[0] = 1'b0;
    check_frame(0, 8'hFF, 4, 0, "t3 second");
    @(negedge clk);
    check("t3 idle after second", mon(0), 4'b1001);

    // T4: reset in the middle of data bit 3 of 0x3C
    din   = 8'h3C;
    lv[0] = 1'b1;
    @(negedge clk);
    lv[0] = 1'b0;
    check("t4 start", mon(0), 4'b0100);
    repeat (17) @(negedge clk);
    check("t4 data bit3", mon(0), 4'b1100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t4 after reset", mon(0), 4'b1001);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check($sformatf("t4 quiet cycle%0d", c), mon(0), 4'b1001);
    end
    din   = 8'h81;
    lv[0] = 1'b1;
    @(negedge clk);
    lv[0] = 1'b0;
    check_frame(0, 8'h81, 4, 0, "t4 81");

    // T5: even parity, 0x07 -> parity 1, 0x03 -> parity 0
    @(negedge clk);
    din   = 8'h07;
    lv[1] = 1'b1;
    @(negedge clk);
    lv[1] = 1'b0;
    check_frame(1, 8'h07, 4, 1, "t5 07");
    @(negedge clk);
    din   = 8'h03;
    lv[1] = 1'b1;
    @(negedge clk);
    lv[1] = 1'b0;
    check_frame(1, 8'h03, 4, 1, "t5 03");

    // T6: one clock per bit, 0xFF
    @(negedge clk);
    din   = 8'hFF;
    lv[2] = 1'b1;
    @(negedge clk);
    lv[2] = 1'b0;
    check_frame(2, 8'hFF, 1, 0, "t6 FF");
    @(negedge clk);
    check("t6 idle after done", mon(2), 4'b1001);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
